// File: rtl/vga_feeder_pkg.sv
// Shared types and constants for the 720p pixel feeder: FSM states, raster
// defaults and the layout of a buffered pixel entry.
package vga_feeder_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int H_ACT_720P = 1280;
  localparam int V_ACT_720P = 720;

  localparam int PIX_W   = 24;
  localparam int ENTRY_W = PIX_W + 1;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;

  // One FIFO word: start-of-frame flag above the packed RGB triple.
  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] rgb;
  } pix_entry_t;

endpackage

// File: rtl/vga_pixel_feeder_if.sv
// Pixel stream from the frame-buffer reader into the feeder.
interface vga_pixel_feeder_if;
  import vga_feeder_pkg::*;

  // A word transfers on every clock edge where iPIX_VALID and oPIX_READY are
  // both high; the source holds data/sof stable while valid is high and ready
  // is low, and iPIX_SOF is meaningful only when iPIX_VALID is high.
  logic [PIX_W-1:0] iPIX_DATA;
  logic             iPIX_SOF;
  logic             iPIX_VALID;
  logic             oPIX_READY;

  modport master (
    output iPIX_DATA,
    output iPIX_SOF,
    output iPIX_VALID,
    input  oPIX_READY
  );

  modport slave (
    input  iPIX_DATA,
    input  iPIX_SOF,
    input  iPIX_VALID,
    output oPIX_READY
  );

endinterface

// File: rtl/vga_pix_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the oldest entry; a write is
// visible at dout only from the cycle after it lands (no bypass path).
module vga_pix_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers the RGB stream and hands one pixel per raster request to the 720p
// timing controller, keeping the stream's SOF locked to raster position (0,0).
module vga_pixel_feeder
  import vga_feeder_pkg::*;
#(
  parameter int H_ACT      = H_ACT_720P,
  parameter int V_ACT      = V_ACT_720P,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  vga_pixel_feeder_if.slave           pix,
  input  logic                        iRequest,
  output logic [7:0]                  oRed,
  output logic [7:0]                  oGreen,
  output logic [7:0]                  oBlue,
  output logic [$clog2(FIFO_DEPTH):0] oLevel,
  output logic                        oUnderflow,
  output logic                        oResync,
  output logic                        oFrame_Done,
  output state_e                      oState
);

  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic             underflow_q, underflow_d;
  logic             slip_q, slip_d;
  logic             resync_q, resync_d;
  logic             frame_done_q, frame_done_d;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENTRY_W-1:0] fifo_dout;
  pix_entry_t         head;
  logic               at_origin, at_last;

  assign pix.oPIX_READY = !fifo_full;
  assign fifo_push      = pix.iPIX_VALID && !fifo_full;
  assign head           = pix_entry_t'(fifo_dout);

  vga_pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({pix.iPIX_SOF, pix.iPIX_DATA}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (oLevel)
  );

  assign at_origin = (x_q == '0) && (y_q == '0);
  assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);

  // Raster position tracks the controller regardless of FSM state.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (iRequest) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    rgb_d        = rgb_q;
    underflow_d  = underflow_q;
    slip_d       = slip_q;
    resync_d     = 1'b0;
    frame_done_d = 1'b0;
    if (iRequest) rgb_d = '0;

    unique case (state_q)
      SYNC: begin
        if (!fifo_empty) begin
          if (head.sof) state_d  = ARMED;
          else          fifo_pop = 1'b1;
        end
      end
      ARMED: begin
        if (iRequest && at_origin && !fifo_empty) begin
          fifo_pop = 1'b1;
          rgb_d    = head.rgb;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (iRequest) begin
          if (fifo_empty) begin
            underflow_d = 1'b1;
            slip_d      = 1'b1;
          end else if (head.sof != at_origin) begin
            resync_d = 1'b1;
            slip_d   = 1'b0;
            state_d  = SYNC;
          end else begin
            fifo_pop = 1'b1;
            rgb_d    = head.rgb;
          end
          // A frame that starved is behind the stream; realign at its end.
          if (at_last) begin
            frame_done_d = 1'b1;
            if (slip_d) begin
              slip_d   = 1'b0;
              resync_d = 1'b1;
              state_d  = SYNC;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q      <= SYNC;
      x_q          <= '0;
      y_q          <= '0;
      rgb_q        <= '0;
      underflow_q  <= 1'b0;
      slip_q       <= 1'b0;
      resync_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rgb_q        <= rgb_d;
      underflow_q  <= underflow_d;
      slip_q       <= slip_d;
      resync_q     <= resync_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oRed        = rgb_q[R_LSB +: 8];
  assign oGreen      = rgb_q[G_LSB +: 8];
  assign oBlue       = rgb_q[B_LSB +: 8];
  assign oUnderflow  = underflow_q;
  assign oResync     = resync_q;
  assign oFrame_Done = frame_done_q;
  assign oState      = state_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder on a shrunken 8x4 raster with a 16-deep buffer.
module tb_vga_pixel_feeder;
  import vga_feeder_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int D  = 16;
  localparam int NP = H * V;

  logic       iCLK;
  logic       iRST_N;
  logic       iRequest;
  logic [7:0] oRed, oGreen, oBlue;
  logic [4:0] oLevel;
  logic       oUnderflow, oResync, oFrame_Done;
  state_e     oState;

  vga_pixel_feeder_if pix_if ();

  vga_pixel_feeder #(
    .H_ACT      (H),
    .V_ACT      (V),
    .FIFO_DEPTH (D)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .pix         (pix_if.slave),
    .iRequest    (iRequest),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oLevel      (oLevel),
    .oUnderflow  (oUnderflow),
    .oResync     (oResync),
    .oFrame_Done (oFrame_Done),
    .oState      (oState)
  );

  // Clock and watchdog
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [24:0] src_q[$];
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb_out();
    return {8'h00, oRed, oGreen, oBlue};
  endfunction

  // Queue a frame's worth of pixels base+0 .. base+count-1 onto the stream.
  task automatic enqueue(input logic [23:0] base, input int count, input int sof_at);
    for (int i = 0; i < count; i++)
      src_q.push_back({(i == sof_at) ? 1'b1 : 1'b0, 24'(base + 24'(i))});
  endtask

  // One clock: offer the queue head on the stream, optionally request a pixel.
  task automatic step(input bit req);
    bit acc;
    if (src_q.size() > 0) begin
      pix_if.iPIX_VALID = 1'b1;
      pix_if.iPIX_DATA  = src_q[0][23:0];
      pix_if.iPIX_SOF   = src_q[0][24];
    end else begin
      pix_if.iPIX_VALID = 1'b0;
    end
    iRequest = req;
    acc = pix_if.iPIX_VALID && pix_if.oPIX_READY;
    @(posedge iCLK);
    #1;
    if (acc) void'(src_q.pop_front());
    pix_if.iPIX_VALID = 1'b0;
    iRequest          = 1'b0;
    if (req) begin
      if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
      else                   check("rgb", rgb_out(), {8'h00, exp_q.pop_front()});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset(input int cycles);
    src_q.delete();
    exp_q.delete();
    iRST_N            = 1'b0;
    iRequest          = 1'b0;
    pix_if.iPIX_VALID = 1'b1;
    pix_if.iPIX_DATA  = 24'hABCDEF;
    pix_if.iPIX_SOF   = 1'b1;
    repeat (cycles) @(posedge iCLK);
    #1;
    iRST_N            = 1'b1;
    pix_if.iPIX_VALID = 1'b0;
    check("rst_level", 32'(oLevel), 32'd0);
    check("rst_ready", 32'(pix_if.oPIX_READY), 32'd1);
    check("rst_rgb", rgb_out(), 32'd0);
    check("rst_state", 32'(oState), 32'(SYNC));
    check("rst_underflow", 32'(oUnderflow), 32'd0);
    check("rst_resync", 32'(oResync), 32'd0);
    check("rst_frame_done", 32'(oFrame_Done), 32'd0);
  endtask

  // A full raster of requests; pixels n >= good_until are expected black.
  task automatic frame_requests(input logic [23:0] base, input int good_until,
                                input int resync_at, input int fd_at);
    for (int n = 0; n < NP; n++) begin
      exp_q.push_back((n < good_until) ? 24'(base + 24'(n)) : 24'h000000);
      step(1'b1);
      check($sformatf("frame_done[%0d]", n), 32'(oFrame_Done), (n == fd_at) ? 32'd1 : 32'd0);
      check($sformatf("resync[%0d]", n), 32'(oResync), (n == resync_at) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    iRST_N            = 1'b0;
    iRequest          = 1'b0;
    pix_if.iPIX_VALID = 1'b0;
    pix_if.iPIX_DATA  = '0;
    pix_if.iPIX_SOF   = 1'b0;

    // 1: reset held 3 clocks with valid high writes nothing
    do_reset(3);
    idle(1);
    check("s1_level_after", 32'(oLevel), 32'd0);

    // 2: nominal frame, one line of pixels buffered ahead of requests
    enqueue(24'h000000, NP, 0);
    idle(H);
    check("s2_prefill_level", 32'(oLevel), 32'd8);
    check("s2_armed", 32'(oState), 32'(ARMED));
    frame_requests(24'h000000, NP, -1, NP - 1);
    idle(1);
    check("s2_fd_cleared", 32'(oFrame_Done), 32'd0);
    check("s2_underflow", 32'(oUnderflow), 32'd0);
    check("s2_state", 32'(oState), 32'(RUN));
    check("s2_level", 32'(oLevel), 32'd0);

    // 3: five non-SOF words before the frame are discarded
    do_reset(1);
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 24'(24'hFF00F0 + 24'(i))});
    enqueue(24'h000000, NP, 0);
    idle(H);
    check("s3_armed", 32'(oState), 32'(ARMED));
    check("s3_level", 32'(oLevel), 32'd3);
    frame_requests(24'h000000, NP, -1, NP - 1);
    check("s3_underflow", 32'(oUnderflow), 32'd0);

    // 4: frame starves after pixel 19, then a complete frame follows
    do_reset(1);
    enqueue(24'h100000, 20, 0);
    idle(H);
    check("s4_underflow_pre", 32'(oUnderflow), 32'd0);
    frame_requests(24'h100000, 20, NP - 1, NP - 1);
    check("s4_underflow", 32'(oUnderflow), 32'd1);
    check("s4_state_sync", 32'(oState), 32'(SYNC));
    enqueue(24'h200000, NP, 0);
    idle(H);
    frame_requests(24'h200000, NP, -1, NP - 1);
    check("s4_underflow_sticky", 32'(oUnderflow), 32'd1);
    check("s4_state_run", 32'(oState), 32'(RUN));

    // 5: fill to capacity; the 17th word waits on ready
    do_reset(1);
    enqueue(24'h300000, D + 1, 0);
    idle(D + 2);
    check("s5_level_full", 32'(oLevel), 32'd16);
    check("s5_ready_low", 32'(pix_if.oPIX_READY), 32'd0);
    check("s5_armed", 32'(oState), 32'(ARMED));
    exp_q.push_back(24'h300000);
    step(1'b1);
    check("s5_level_after_pop", 32'(oLevel), 32'd15);
    check("s5_ready_high", 32'(pix_if.oPIX_READY), 32'd1);
    src_q.delete();

    // 6: an early SOF at pixel 10 forces a resync; next frame realigns
    do_reset(1);
    enqueue(24'h400000, 10, 0);
    enqueue(24'h500000, NP, 0);
    idle(H);
    frame_requests(24'h400000, 10, 10, -1);
    check("s6_armed", 32'(oState), 32'(ARMED));
    frame_requests(24'h500000, NP, -1, NP - 1);
    check("s6_state_run", 32'(oState), 32'(RUN));
    check("s6_underflow", 32'(oUnderflow), 32'd0);

    // 6b: reset in the middle of a frame
    enqueue(24'h600000, NP, 0);
    idle(H);
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back(24'(24'h600000 + 24'(n)));
      step(1'b1);
    end
    check("s6_level_mid", 32'(oLevel), 32'd8);
    do_reset(1);
    idle(2);
    check("s6_level_post_rst", 32'(oLevel), 32'd0);
    check("s6_state_post_rst", 32'(oState), 32'(SYNC));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
- Upstream neighbour of the 720p VGA timing controller.
- Buffers a 24-bit RGB pixel stream from the frame-buffer reader (valid/ready handshake, start-of-frame marker).
- Returns one pixel per controller request cycle on iRed/iGreen/iBlue.
- Keeps the stream frame-aligned to the display raster; flags and recovers from underflow and misalignment.

Parameters:
- H_ACT, 1280, active pixels per line (request cycles per line).
- V_ACT, 720, active lines per frame.
- FIFO_DEPTH, 1024, pixel buffer entries; must be a power of 2, at least 4.

Ports:
- iCLK  in  1  pixel clock (74.25 MHz), shared with the timing controller.
- iRST_N  in  1  reset.
- iPIX_DATA  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- iPIX_SOF  in  1  marks the first pixel of a frame; qualified by iPIX_VALID.
- iPIX_VALID  in  1  upstream data valid.
- oPIX_READY  out  1  buffer can accept; combinational !full.
- iRequest  in  1  pixel request from the timing controller; one pixel consumed per high cycle.
- oRed, oGreen, oBlue  out  8 each  pixel to the timing controller.
- oLevel  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- oUnderflow  out  1  sticky; set on a request while the FIFO is empty.
- oResync  out  1  one-cycle pulse on loss of alignment.
- oFrame_Done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
Clock and reset:
- Single clock iCLK; reset iRST_N is synchronous and active-low.
- Reset values: oRed/oGreen/oBlue=0, oLevel=0, oUnderflow=0, oResync=0, oFrame_Done=0, FIFO empty, so oPIX_READY=1.
- Reset also sets state=SYNC and position counters x=0, y=0.
- Reset mid-operation discards all buffered pixels.

FIFO:
- 25-bit entries {sof, rgb}, show-ahead, so the head is visible before it is popped.
- Write when iPIX_VALID && oPIX_READY.
- No bypass: a write into an empty FIFO is not readable until the next cycle.
- Simultaneous push and pop: oLevel is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- A write while full cannot occur because oPIX_READY=0.

Raster position:
- x/y advance on every iRequest cycle in every state.
- x wraps at H_ACT-1 and increments y; y wraps at V_ACT-1.
- Position (0,0) is the first request of a display frame. The controller starts at frame top after reset, so the counters begin aligned.

Output timing:
- oRed/oGreen/oBlue are registered and update the cycle after the iRequest cycle (latency 1).
- In cycles with no request they hold their previous value.
- A request that is not served by a pop outputs 0 (black).

State machine:
- SYNC
  - Each cycle, if not empty and head.sof=0: pop and discard.
  - If head.sof=1: go to ARMED without popping.
  - Requests are answered with black.
- ARMED
  - Head is held.
  - iRequest at (x,y)=(0,0): pop the head, output it, go to RUN.
  - Requests at other positions are answered with black.
- RUN, on each iRequest:
  - If empty: output black, set oUnderflow, set internal slip.
  - Else if head.sof differs from (x,y)==(0,0): do not pop, pulse oResync, go to SYNC.
  - Else: pop and output the head.
  - After the request at (H_ACT-1, V_ACT-1): pulse oFrame_Done next cycle. If slip is set, clear slip, pulse oResync, go to SYNC; otherwise stay in RUN.
- oUnderflow clears only on reset.

Decomposition:
- Package vga_feeder_pkg: state enum {SYNC, ARMED, RUN}; 720p constants H_ACT/V_ACT defaults; pixel field offsets.
- Sub-module vga_pix_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, level.
- The top level holds the raster counters, state machine and output registers.

Test Plan:
Scenarios 1-6 use H_ACT=8, V_ACT=4, FIFO_DEPTH=16.
1. Reset: hold iRST_N=0 for 3 clocks with iPIX_VALID=1 -> no writes; after release oLevel=0, oPIX_READY=1, RGB=0, state SYNC.
2. Nominal: push 32 pixels, value n=0..31, SOF on n=0, one line ahead of requests. Issue 4 bursts of 8 requests -> output n one cycle after each request; oFrame_Done pulses once, after the request at n=31; no oUnderflow.
3. Pre-SOF garbage: 5 non-SOF words, then the scenario 2 frame -> the 5 words are dropped in SYNC; first output is 0x000000 = pixel 0; ARMED→RUN exactly at (0,0).
4. Underflow: frame stops after pixel 19 -> requests 20..31 return 0 and oUnderflow=1. oResync pulses after (7,3). The next complete frame displays correctly while oUnderflow stays 1.
5. Full: 16 writes with no requests -> oLevel=16, oPIX_READY=0, 17th word not accepted. Then one request at (0,0) -> oLevel=15, oPIX_READY=1.
6. Misalignment and mid-run reset: SOF set on pixel 10 -> oResync at request 10, state SYNC, realign at next frame. Reset asserted mid-frame -> all outputs return to reset values next cycle.
